// File: rtl/stopwatch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : stopwatch_pkg
//  Purpose  : Shared widths, terminal values and control-FSM status encodings.
//  Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int MIN_W    = 7;
    localparam int SEC_W    = 6;
    localparam int HUND_W   = 7;
    localparam int HUND_MAX = 99;
    localparam int SEC_MAX  = 59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } sw_status_e;

endpackage
`default_nettype wire

// File: rtl/stopwatch_time_counter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : stopwatch_time_counter_if
//  Purpose  : Control inputs and display/status outputs of the time counter.
//  Revision : 1.0 - initial release
// ============================================================================
interface stopwatch_time_counter_if;
    import stopwatch_pkg::*;

    logic              count_en;
    logic              clear;
    logic              lap;
    logic [MIN_W-1:0]  disp_min;
    logic [SEC_W-1:0]  disp_sec;
    logic [HUND_W-1:0] disp_hund;
    logic              lap_active;
    logic              tick;
    logic              overflow;

    modport master (
        output count_en, clear, lap,
        input  disp_min, disp_sec, disp_hund, lap_active, tick, overflow
    );

    modport slave (
        input  count_en, clear, lap,
        output disp_min, disp_sec, disp_hund, lap_active, tick, overflow
    );

endinterface
`default_nettype wire

// File: rtl/stopwatch_time_counter_wrap_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : wrap_counter
//  Purpose  : Modulo-(MAX+1) counter stage; carry flags the wrap edge.
//  Revision : 1.0 - initial release
// ============================================================================
module wrap_counter #(
    parameter int WIDTH = 7,
    parameter int MAX   = 99
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clr,
    input  wire logic             inc,
    output logic [WIDTH-1:0]      value,
    output logic                  carry
);

    logic [WIDTH-1:0] r_value;

    assign carry = inc & (r_value == WIDTH'(MAX));
    assign value = r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= carry ? '0 : r_value + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stopwatch_time_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : stopwatch_time_counter
//  Purpose  : 10 ms prescaler, mm:ss.hh cascade, lap freeze and overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int CLKS_PER_TICK = 1_000_000,
    parameter int MAX_MINUTES   = 99
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    stopwatch_time_counter_if.slave   bus
);

    localparam int             PS_W    = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLKS_PER_TICK - 1);

    logic [PS_W-1:0]   r_ps;
    logic              w_tick;
    logic [HUND_W-1:0] w_hund, w_hund_next;
    logic [SEC_W-1:0]  w_sec, w_sec_next;
    logic [MIN_W-1:0]  w_min, w_min_next;
    logic              w_hund_carry, w_sec_carry, w_min_carry;
    logic [HUND_W-1:0] r_lap_hund;
    logic [SEC_W-1:0]  r_lap_sec;
    logic [MIN_W-1:0]  r_lap_min;
    logic              r_lap_active;
    logic              r_overflow;

    // Prescaler holds while paused so resume keeps the sub-tick phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ps <= '0;
        end else if (bus.clear) begin
            r_ps <= '0;
        end else if (bus.count_en) begin
            r_ps <= (r_ps == PS_LAST) ? '0 : r_ps + 1'b1;
        end
    end

    assign w_tick = bus.count_en & ~bus.clear & (r_ps == PS_LAST);

    wrap_counter #(.WIDTH(HUND_W), .MAX(HUND_MAX)) u_hund (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear), .inc(w_tick),
        .value(w_hund), .carry(w_hund_carry)
    );

    wrap_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear), .inc(w_hund_carry),
        .value(w_sec), .carry(w_sec_carry)
    );

    wrap_counter #(.WIDTH(MIN_W), .MAX(MAX_MINUTES)) u_min (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear), .inc(w_sec_carry),
        .value(w_min), .carry(w_min_carry)
    );

    // Post-edge live time, so a lap capture matches what the live path shows next.
    assign w_hund_next = w_hund_carry ? '0 : w_hund + HUND_W'(w_tick);
    assign w_sec_next  = w_sec_carry  ? '0 : w_sec  + SEC_W'(w_hund_carry);
    assign w_min_next  = w_min_carry  ? '0 : w_min  + MIN_W'(w_sec_carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lap_active <= 1'b0;
            r_lap_min    <= '0;
            r_lap_sec    <= '0;
            r_lap_hund   <= '0;
        end else if (bus.clear) begin
            r_lap_active <= 1'b0;
            r_lap_min    <= '0;
            r_lap_sec    <= '0;
            r_lap_hund   <= '0;
        end else if (bus.lap) begin
            r_lap_active <= ~r_lap_active;
            if (!r_lap_active) begin
                r_lap_min  <= w_min_next;
                r_lap_sec  <= w_sec_next;
                r_lap_hund <= w_hund_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (bus.clear) begin
            r_overflow <= 1'b0;
        end else if (w_min_carry) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.disp_min   = r_lap_active ? r_lap_min  : w_min;
    assign bus.disp_sec   = r_lap_active ? r_lap_sec  : w_sec;
    assign bus.disp_hund  = r_lap_active ? r_lap_hund : w_hund;
    assign bus.lap_active = r_lap_active;
    assign bus.tick       = w_tick;
    assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_time_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_time_counter
//  Purpose  : Directed self-checking bench for stopwatch_time_counter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_time_counter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    stopwatch_time_counter_if ifa ();
    stopwatch_time_counter_if ifb ();

    // ifa: 4-clock prescaler, full minute range; ifb: 1-clock prescaler, 1-minute wrap
    stopwatch_time_counter #(.CLKS_PER_TICK(4), .MAX_MINUTES(99)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );

    stopwatch_time_counter #(.CLKS_PER_TICK(1), .MAX_MINUTES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.count_en = 1'b0; ifa.clear = 1'b0; ifa.lap = 1'b0;
        ifb.count_en = 1'b0; ifb.clear = 1'b0; ifb.lap = 1'b0;
        #1;
        checks++;
        if ({ifa.disp_min, ifa.disp_sec, ifa.disp_hund, ifa.lap_active, ifa.tick, ifa.overflow} !== 23'd0) begin
            errors++;
            $display("FAIL reset_init_a: got %0d:%0d.%0d lap=%b tick=%b ovf=%b, want all 0",
                     ifa.disp_min, ifa.disp_sec, ifa.disp_hund, ifa.lap_active, ifa.tick, ifa.overflow);
        end
        checks++;
        if ({ifb.disp_min, ifb.disp_sec, ifb.disp_hund, ifb.lap_active, ifb.tick, ifb.overflow} !== 23'd0) begin
            errors++;
            $display("FAIL reset_init_b: got %0d:%0d.%0d lap=%b tick=%b ovf=%b, want all 0",
                     ifb.disp_min, ifb.disp_sec, ifb.disp_hund, ifb.lap_active, ifb.tick, ifb.overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // 317 ticks of 4 clocks plus one extra clock leaves the prescaler mid-tick
        ifa.count_en = 1'b1;
        repeat (1269) @(negedge clk);
        checks++;
        if ({ifa.disp_min, ifa.disp_sec, ifa.disp_hund} !== {7'd0, 6'd3, 7'd17}) begin
            errors++;
            $display("FAIL reset_precount: got %0d:%0d.%0d, want 0:3.17",
                     ifa.disp_min, ifa.disp_sec, ifa.disp_hund);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ifa.disp_min, ifa.disp_sec, ifa.disp_hund, ifa.lap_active, ifa.tick, ifa.overflow} !== 23'd0) begin
            errors++;
            $display("FAIL reset_async: got %0d:%0d.%0d lap=%b tick=%b ovf=%b, want all 0",
                     ifa.disp_min, ifa.disp_sec, ifa.disp_hund, ifa.lap_active, ifa.tick, ifa.overflow);
        end
        ifa.count_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ifa.disp_min, ifa.disp_sec, ifa.disp_hund, ifa.lap_active, ifa.tick, ifa.overflow} !== 23'd0) begin
            errors++;
            $display("FAIL reset_hold: got %0d:%0d.%0d lap=%b tick=%b ovf=%b, want all 0",
                     ifa.disp_min, ifa.disp_sec, ifa.disp_hund, ifa.lap_active, ifa.tick, ifa.overflow);
        end
    endtask

    task automatic test_basic_count();
        for (int i = 1; i <= 16; i++) begin
            ifa.count_en = 1'b1;
            #1;
            checks++;
            if (ifa.tick !== ((i % 4) == 0)) begin
                errors++;
                $display("FAIL basic_tick cycle %0d: got %b, want %b", i, ifa.tick, ((i % 4) == 0));
            end
            @(negedge clk);
        end
        ifa.count_en = 1'b0;
        checks++;
        if ({ifa.disp_min, ifa.disp_sec, ifa.disp_hund} !== {7'd0, 6'd0, 7'd4}) begin
            errors++;
            $display("FAIL basic_time: got %0d:%0d.%0d, want 0:0.4",
                     ifa.disp_min, ifa.disp_sec, ifa.disp_hund);
        end
    endtask

    task automatic test_pause();
        ifa.clear = 1'b1;
        @(negedge clk);
        ifa.clear = 1'b0;
        checks++;
        if ({ifa.disp_min, ifa.disp_sec, ifa.disp_hund} !== 20'd0) begin
            errors++;
            $display("FAIL pause_clear: got %0d:%0d.%0d, want 0:0.0",
                     ifa.disp_min, ifa.disp_sec, ifa.disp_hund);
        end
        ifa.count_en = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (ifa.disp_hund !== 7'd1) begin
            errors++;
            $display("FAIL pause_first_run: got hund %0d, want 1", ifa.disp_hund);
        end
        ifa.count_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (ifa.tick !== 1'b0) begin
                errors++;
                $display("FAIL pause_tick_idle cycle %0d: got %b, want 0", i, ifa.tick);
            end
            @(negedge clk);
        end
        ifa.count_en = 1'b1;
        repeat (2) @(negedge clk);
        ifa.count_en = 1'b0;
        checks++;
        if (ifa.disp_hund !== 7'd2) begin
            errors++;
            $display("FAIL pause_resume: got hund %0d, want 2", ifa.disp_hund);
        end
    endtask

    task automatic test_carry_wrap();
        ifb.count_en = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if ({ifb.disp_min, ifb.disp_sec, ifb.disp_hund} !== {7'd0, 6'd1, 7'd0}) begin
            errors++;
            $display("FAIL carry_sec: got %0d:%0d.%0d, want 0:1.0", ifb.disp_min, ifb.disp_sec, ifb.disp_hund);
        end
        #1;
        checks++;
        if (ifb.tick !== 1'b1) begin
            errors++;
            $display("FAIL carry_tick_en: got %b, want 1", ifb.tick);
        end
        repeat (5900) @(negedge clk);
        checks++;
        if ({ifb.disp_min, ifb.disp_sec, ifb.disp_hund, ifb.overflow} !== {7'd1, 6'd0, 7'd0, 1'b0}) begin
            errors++;
            $display("FAIL carry_min: got %0d:%0d.%0d ovf=%b, want 1:0.0 ovf=0",
                     ifb.disp_min, ifb.disp_sec, ifb.disp_hund, ifb.overflow);
        end
        repeat (5999) @(negedge clk);
        checks++;
        if ({ifb.disp_min, ifb.disp_sec, ifb.disp_hund, ifb.overflow} !== {7'd1, 6'd59, 7'd99, 1'b0}) begin
            errors++;
            $display("FAIL carry_terminal: got %0d:%0d.%0d ovf=%b, want 1:59.99 ovf=0",
                     ifb.disp_min, ifb.disp_sec, ifb.disp_hund, ifb.overflow);
        end
        @(negedge clk);
        checks++;
        if ({ifb.disp_min, ifb.disp_sec, ifb.disp_hund, ifb.overflow} !== {7'd0, 6'd0, 7'd0, 1'b1}) begin
            errors++;
            $display("FAIL carry_wrap: got %0d:%0d.%0d ovf=%b, want 0:0.0 ovf=1",
                     ifb.disp_min, ifb.disp_sec, ifb.disp_hund, ifb.overflow);
        end
        repeat (5) @(negedge clk);
        ifb.count_en = 1'b0;
        #1;
        checks++;
        if ({ifb.disp_hund, ifb.overflow, ifb.tick} !== {7'd5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL carry_after_wrap: got hund=%0d ovf=%b tick=%b, want 5 1 0",
                     ifb.disp_hund, ifb.overflow, ifb.tick);
        end
        @(negedge clk);
    endtask

    task automatic test_lap();
        ifb.clear = 1'b1;
        @(negedge clk);
        ifb.clear = 1'b0;
        checks++;
        if ({ifb.disp_min, ifb.disp_sec, ifb.disp_hund, ifb.overflow} !== 21'd0) begin
            errors++;
            $display("FAIL lap_clear: got %0d:%0d.%0d ovf=%b, want 0:0.0 ovf=0",
                     ifb.disp_min, ifb.disp_sec, ifb.disp_hund, ifb.overflow);
        end
        ifb.count_en = 1'b1;
        for (int k = 1; k <= 85; k++) begin
            ifb.lap = (k == 50) || (k == 80);
            @(negedge clk);
            ifb.lap = 1'b0;
            if (k == 50 || k == 60) begin
                checks++;
                if ({ifb.disp_sec, ifb.disp_hund, ifb.lap_active} !== {6'd0, 7'd50, 1'b1}) begin
                    errors++;
                    $display("FAIL lap_freeze at %0d: got %0d.%0d active=%b, want 0.50 active=1",
                             k, ifb.disp_sec, ifb.disp_hund, ifb.lap_active);
                end
            end
            if (k == 80 || k == 85) begin
                checks++;
                if ({ifb.disp_sec, ifb.disp_hund, ifb.lap_active} !== {6'd0, 7'(k), 1'b0}) begin
                    errors++;
                    $display("FAIL lap_release at %0d: got %0d.%0d active=%b, want 0.%0d active=0",
                             k, ifb.disp_sec, ifb.disp_hund, ifb.lap_active, k);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        // Live is 0:00.85 with count_en high; 11915 more ticks reach the wrap
        repeat (11915) @(negedge clk);
        ifb.lap = 1'b1;
        @(negedge clk);
        ifb.lap = 1'b0;
        checks++;
        if ({ifb.overflow, ifb.lap_active, ifb.disp_hund} !== {1'b1, 1'b1, 7'd1}) begin
            errors++;
            $display("FAIL simul_setup: got ovf=%b active=%b hund=%0d, want 1 1 1",
                     ifb.overflow, ifb.lap_active, ifb.disp_hund);
        end
        ifb.clear = 1'b1;
        ifb.lap   = 1'b1;
        #1;
        checks++;
        if (ifb.tick !== 1'b0) begin
            errors++;
            $display("FAIL simul_tick: got %b, want 0", ifb.tick);
        end
        @(negedge clk);
        ifb.clear    = 1'b0;
        ifb.lap      = 1'b0;
        ifb.count_en = 1'b0;
        #1;
        checks++;
        if ({ifb.disp_min, ifb.disp_sec, ifb.disp_hund, ifb.lap_active, ifb.tick, ifb.overflow} !== 23'd0) begin
            errors++;
            $display("FAIL simul_clear: got %0d:%0d.%0d lap=%b tick=%b ovf=%b, want all 0",
                     ifb.disp_min, ifb.disp_sec, ifb.disp_hund, ifb.lap_active, ifb.tick, ifb.overflow);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_count();
        test_pause();
        test_carry_wrap();
        test_lap();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
